// File: rtl/parc_core_rob_result_buffer_if.sv
// Bus between the ROB/functional units and the ROB result buffer:
// fill, squash, commit, bypass lookup and the register-file write port.
interface parc_core_rob_result_buffer_if #(
  parameter int DATA_W  = 32,
  parameter int SLOT_W  = 4,
  parameter int COUNT_W = 16
);
  logic               fill_val;
  logic [SLOT_W-1:0]  fill_slot;
  logic [DATA_W-1:0]  fill_data;
  logic               squash_val;
  logic [SLOT_W-1:0]  squash_slot;
  logic               commit_wen;
  logic [SLOT_W-1:0]  commit_slot;
  logic [4:0]         commit_rf_waddr;
  logic [SLOT_W-1:0]  byp_slot;
  logic               byp_hit;
  logic [DATA_W-1:0]  byp_data;
  logic               rf_wen;
  logic [4:0]         rf_waddr;
  logic [DATA_W-1:0]  rf_wdata;
  logic               commit_err;
  logic [COUNT_W-1:0] commit_count;

  modport master (
    output fill_val, fill_slot, fill_data, squash_val, squash_slot,
           commit_wen, commit_slot, commit_rf_waddr, byp_slot,
    input  byp_hit, byp_data, rf_wen, rf_waddr, rf_wdata, commit_err, commit_count
  );

  modport slave (
    input  fill_val, fill_slot, fill_data, squash_val, squash_slot,
           commit_wen, commit_slot, commit_rf_waddr, byp_slot,
    output byp_hit, byp_data, rf_wen, rf_waddr, rf_wdata, commit_err, commit_count
  );
endinterface

// File: rtl/parc_core_rob_result_buffer.sv
// ROB result buffer: holds functional-unit results by ROB slot until commit,
// then drives the register-file write port one cycle later; also serves bypass.
module parc_core_rob_result_buffer #(
  parameter int DATA_W  = 32,
  parameter int SLOT_W  = 4,
  parameter int COUNT_W = 16
) (
  input  logic clk,
  input  logic reset,
  parc_core_rob_result_buffer_if.slave rb
);
  localparam int DEPTH = 1 << SLOT_W;

  logic [DEPTH-1:0]   present;
  logic [DEPTH-1:0]   present_nxt;
  logic [DATA_W-1:0]  data_mem [DEPTH];

  logic               fwd_p0;
  logic               vld_p0;
  logic               err_p0;
  logic [DATA_W-1:0]  src_data_p0;

  logic               rf_wen_p1;
  logic [4:0]         rf_waddr_p1;
  logic [DATA_W-1:0]  rf_wdata_p1;
  logic               commit_err_q;
  logic [COUNT_W-1:0] commit_count_q;

  // ---- p0: commit decode; a same-cycle fill to the committing slot is forwarded
  always_comb begin
    fwd_p0      = rb.fill_val && (rb.fill_slot == rb.commit_slot);
    src_data_p0 = fwd_p0 ? rb.fill_data : data_mem[rb.commit_slot];
    vld_p0      = rb.commit_wen && (fwd_p0 || present[rb.commit_slot]);
    err_p0      = rb.commit_wen && !vld_p0;
  end

  // Priority: fill < squash < retiring commit.
  always_comb begin
    present_nxt = present;
    if (rb.fill_val)   present_nxt[rb.fill_slot]   = 1'b1;
    if (rb.squash_val) present_nxt[rb.squash_slot] = 1'b0;
    if (vld_p0)        present_nxt[rb.commit_slot] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) present <= '0;
    else        present <= present_nxt;
  end

  always_ff @(posedge clk) begin
    if (rb.fill_val) data_mem[rb.fill_slot] <= rb.fill_data;
  end

  // ---- p1: registered register-file write port and retirement bookkeeping
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rf_wen_p1      <= 1'b0;
      rf_waddr_p1    <= '0;
      rf_wdata_p1    <= '0;
      commit_err_q   <= 1'b0;
      commit_count_q <= '0;
    end else begin
      rf_wen_p1 <= vld_p0 && (rb.commit_rf_waddr != 5'd0);
      if (vld_p0 && (rb.commit_rf_waddr != 5'd0)) begin
        rf_waddr_p1 <= rb.commit_rf_waddr;
        rf_wdata_p1 <= src_data_p0;
      end
      if (vld_p0) commit_count_q <= commit_count_q + COUNT_W'(1);
      if (err_p0) commit_err_q   <= 1'b1;
    end
  end

  // Bypass sees only registered state; same-cycle fills appear next cycle.
  always_comb begin
    rb.byp_hit  = present[rb.byp_slot];
    rb.byp_data = present[rb.byp_slot] ? data_mem[rb.byp_slot] : '0;
  end

  assign rb.rf_wen       = rf_wen_p1;
  assign rb.rf_waddr     = rf_waddr_p1;
  assign rb.rf_wdata     = rf_wdata_p1;
  assign rb.commit_err   = commit_err_q;
  assign rb.commit_count = commit_count_q;
endmodule

// File: tb/tb_parc_core_rob_result_buffer.sv
// Self-checking bench for parc_core_rob_result_buffer: scoreboard of expected
// register-file writes, checked by a monitor on the falling clock edge.
module tb_parc_core_rob_result_buffer;
  localparam int DATA_W  = 32;
  localparam int SLOT_W  = 4;
  localparam int COUNT_W = 16;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;
  int   pass_cnt = 0;
  int   total_cnt = 0;
  logic [COUNT_W-1:0] exp_count = '0;

  typedef struct {
    logic [4:0]        waddr;
    logic [DATA_W-1:0] wdata;
    int                cyc;
  } exp_t;
  exp_t sb[$];

  parc_core_rob_result_buffer_if #(.DATA_W(DATA_W), .SLOT_W(SLOT_W), .COUNT_W(COUNT_W)) bus ();

  parc_core_rob_result_buffer #(.DATA_W(DATA_W), .SLOT_W(SLOT_W), .COUNT_W(COUNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .rb    (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic idle_inputs();
    bus.fill_val = 1'b0;        bus.fill_slot = '0;   bus.fill_data = '0;
    bus.squash_val = 1'b0;      bus.squash_slot = '0;
    bus.commit_wen = 1'b0;      bus.commit_slot = '0; bus.commit_rf_waddr = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    idle_inputs();
    reset = 1'b0;
    step();
    step();
    sb.delete();
    exp_count = '0;
    reset = 1'b1;
    step();
  endtask

  // Drive a commit for this cycle; a write is expected when addr is non-zero.
  task automatic drive_commit(input logic [SLOT_W-1:0] slot, input logic [4:0] waddr,
                              input logic [DATA_W-1:0] wdata, input bit expect_ok);
    exp_t e;
    bus.commit_wen = 1'b1;
    bus.commit_slot = slot;
    bus.commit_rf_waddr = waddr;
    if (expect_ok) begin
      exp_count = exp_count + COUNT_W'(1);
      if (waddr != 5'd0) begin
        e.waddr = waddr; e.wdata = wdata; e.cyc = cyc + 1;
        sb.push_back(e);
      end
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
        exp_t e;
        e = sb.pop_front();
        total_cnt++;
        if (bus.rf_wen !== 1'b1 || bus.rf_waddr !== e.waddr || bus.rf_wdata !== e.wdata)
          $display("FAIL rf_write cyc=%0d got wen=%b addr=%0d data=%h expected wen=1 addr=%0d data=%h",
                   cyc, bus.rf_wen, bus.rf_waddr, bus.rf_wdata, e.waddr, e.wdata);
        else pass_cnt++;
      end else if (bus.rf_wen !== 1'b0) begin
        total_cnt++;
        $display("FAIL unexpected_rf_write cyc=%0d got wen=%b addr=%0d data=%h expected wen=0",
                 cyc, bus.rf_wen, bus.rf_waddr, bus.rf_wdata);
      end
    end
  endtask

  task automatic test_reset();
    apply_reset();
    total_cnt++;
    if (bus.rf_wen !== 1'b0 || bus.rf_waddr !== 5'd0 || bus.rf_wdata !== '0)
      $display("FAIL reset_rf got wen=%b addr=%0d data=%h expected 0/0/0", bus.rf_wen, bus.rf_waddr, bus.rf_wdata);
    else pass_cnt++;
    total_cnt++;
    if (bus.commit_err !== 1'b0 || bus.commit_count !== '0)
      $display("FAIL reset_status got err=%b count=%0d expected 0/0", bus.commit_err, bus.commit_count);
    else pass_cnt++;
    for (int s = 0; s < 16; s++) begin
      bus.byp_slot = SLOT_W'(s);
      #1;
      total_cnt++;
      if (bus.byp_hit !== 1'b0 || bus.byp_data !== '0)
        $display("FAIL reset_byp slot=%0d got hit=%b data=%h expected 0/0", s, bus.byp_hit, bus.byp_data);
      else pass_cnt++;
    end
  endtask

  task automatic test_fill_commit();
    bus.fill_val = 1'b1; bus.fill_slot = 4'd3; bus.fill_data = 32'hDEADBEEF;
    bus.byp_slot = 4'd3;
    #1;
    total_cnt++;
    if (bus.byp_hit !== 1'b0)
      $display("FAIL byp_same_cycle_fill got hit=%b expected 0", bus.byp_hit);
    else pass_cnt++;
    step();
    idle_inputs();
    drive_commit(4'd3, 5'd7, 32'hDEADBEEF, 1'b1);
    #1;
    total_cnt++;
    if (bus.byp_hit !== 1'b1 || bus.byp_data !== 32'hDEADBEEF)
      $display("FAIL byp_commit_cycle got hit=%b data=%h expected 1/deadbeef", bus.byp_hit, bus.byp_data);
    else pass_cnt++;
    step();
    idle_inputs();
    total_cnt++;
    if (bus.commit_count !== exp_count || bus.byp_hit !== 1'b0)
      $display("FAIL fill_commit_state got count=%0d hit=%b expected %0d/0", bus.commit_count, bus.byp_hit, exp_count);
    else pass_cnt++;
    step();
  endtask

  task automatic test_forward();
    bus.fill_val = 1'b1; bus.fill_slot = 4'd5; bus.fill_data = 32'h1234;
    drive_commit(4'd5, 5'd2, 32'h1234, 1'b1);
    step();
    idle_inputs();
    bus.byp_slot = 4'd5;
    #1;
    total_cnt++;
    if (bus.byp_hit !== 1'b0 || bus.commit_count !== exp_count)
      $display("FAIL forward_state got hit=%b count=%0d expected 0/%0d", bus.byp_hit, bus.commit_count, exp_count);
    else pass_cnt++;
    step();
  endtask

  task automatic test_commit_error();
    drive_commit(4'd9, 5'd4, '0, 1'b0);
    step();
    idle_inputs();
    total_cnt++;
    if (bus.commit_err !== 1'b1 || bus.commit_count !== exp_count)
      $display("FAIL commit_err_set got err=%b count=%0d expected 1/%0d", bus.commit_err, bus.commit_count, exp_count);
    else pass_cnt++;
    bus.fill_val = 1'b1; bus.fill_slot = 4'd9; bus.fill_data = 32'hA5A5_0009;
    step();
    idle_inputs();
    drive_commit(4'd9, 5'd3, 32'hA5A5_0009, 1'b1);
    step();
    idle_inputs();
    total_cnt++;
    if (bus.commit_err !== 1'b1 || bus.commit_count !== exp_count)
      $display("FAIL commit_err_sticky got err=%b count=%0d expected 1/%0d", bus.commit_err, bus.commit_count, exp_count);
    else pass_cnt++;
    step();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 16; i++) begin
      bus.fill_val = 1'b1; bus.fill_slot = SLOT_W'(i); bus.fill_data = DATA_W'(32'h100 + i);
      step();
    end
    idle_inputs();
    for (int i = 0; i < 16; i++) begin
      drive_commit(SLOT_W'(i), 5'(i), DATA_W'(32'h100 + i), 1'b1);
      step();
    end
    idle_inputs();
    step();
    total_cnt++;
    if (bus.commit_count !== exp_count || sb.size() != 0)
      $display("FAIL back_to_back got count=%0d pending=%0d expected %0d/0", bus.commit_count, sb.size(), exp_count);
    else pass_cnt++;
  endtask

  task automatic test_squash();
    apply_reset();
    bus.fill_val = 1'b1; bus.fill_slot = 4'd4; bus.fill_data = 32'h44;
    step();
    bus.fill_data = 32'h45;
    bus.squash_val = 1'b1; bus.squash_slot = 4'd4;
    step();
    idle_inputs();
    bus.byp_slot = 4'd4;
    #1;
    total_cnt++;
    if (bus.byp_hit !== 1'b0 || bus.commit_err !== 1'b0)
      $display("FAIL squash_wins got hit=%b err=%b expected 0/0", bus.byp_hit, bus.commit_err);
    else pass_cnt++;
    drive_commit(4'd4, 5'd6, '0, 1'b0);
    step();
    idle_inputs();
    total_cnt++;
    if (bus.commit_err !== 1'b1 || bus.commit_count !== exp_count)
      $display("FAIL squash_commit_err got err=%b count=%0d expected 1/%0d", bus.commit_err, bus.commit_count, exp_count);
    else pass_cnt++;
    step();
  endtask

  task automatic test_reset_midflight();
    bus.fill_val = 1'b1; bus.fill_slot = 4'd1; bus.fill_data = 32'h1111;
    step();
    idle_inputs();
    bus.commit_wen = 1'b1; bus.commit_slot = 4'd1; bus.commit_rf_waddr = 5'd9;
    step();
    idle_inputs();
    reset = 1'b0;
    #1;
    total_cnt++;
    if (bus.rf_wen !== 1'b0 || bus.commit_count !== '0)
      $display("FAIL midflight_reset got wen=%b count=%0d expected 0/0", bus.rf_wen, bus.commit_count);
    else pass_cnt++;
    step();
    reset = 1'b1;
    exp_count = '0;
    bus.byp_slot = 4'd1;
    step();
    total_cnt++;
    if (bus.byp_hit !== 1'b0 || bus.rf_wen !== 1'b0 || bus.commit_count !== '0)
      $display("FAIL after_reset got hit=%b wen=%b count=%0d expected 0/0/0", bus.byp_hit, bus.rf_wen, bus.commit_count);
    else pass_cnt++;
    step();
  endtask

  initial begin
    idle_inputs();
    bus.byp_slot = '0;
    fork monitor(); join_none
    test_reset();
    test_fill_commit();
    test_forward();
    test_commit_error();
    test_back_to_back();
    test_squash();
    test_reset_midflight();
    step();
    step();
    total_cnt++;
    if (sb.size() != 0)
      $display("FAIL scoreboard_drain got pending=%0d expected 0", sb.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/parc_core_rob_result_buffer.md
Name: parc_core_rob_result_buffer

Overview:
- Data-side partner of the core reorder buffer's fill/commit interface.
- Receives results from the functional units, keyed by ROB slot, and holds them until commit.
- When the ROB issues a commit for a slot, the block drives the register-file write port with that slot's data, one cycle later.
- Also provides a by-slot bypass lookup for operand forwarding, and a squash input to discard wrong-path results.

Parameters:
- DATA_W, 32, result/register data width
- SLOT_W, 4, ROB slot index width; the buffer holds 2^SLOT_W entries (16)
- COUNT_W, 16, width of the retired-instruction counter

Ports:
- clk  input  1  core clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-low reset
- fill_val  input  1  a functional-unit result is valid this cycle
- fill_slot  input  SLOT_W  ROB slot the result belongs to
- fill_data  input  DATA_W  result value
- squash_val  input  1  discard the result held in squash_slot
- squash_slot  input  SLOT_W  slot to discard
- commit_wen  input  1  ROB commits the head entry this cycle
- commit_slot  input  SLOT_W  slot being committed
- commit_rf_waddr  input  5  architectural destination register of the committing entry
- byp_slot  input  SLOT_W  bypass lookup slot
- byp_hit  output  1  the looked-up slot holds a result
- byp_data  output  DATA_W  that result; 0 when byp_hit=0
- rf_wen  output  1  register-file write enable (registered)
- rf_waddr  output  5  register-file write address (registered)
- rf_wdata  output  DATA_W  register-file write data (registered)
- commit_err  output  1  sticky: a commit arrived for a slot with no result
- commit_count  output  COUNT_W  number of successful retirements, wraps modulo 2^COUNT_W

Behaviour:
- Storage: present[2^SLOT_W] bits plus data[2^SLOT_W][DATA_W]. The data array is not reset.
- Reset (asynchronous, active-low) clears: present, rf_wen, rf_waddr, rf_wdata, commit_err, commit_count.
- Fill: on fill_val, data[fill_slot] <= fill_data and present[fill_slot] <= 1.
  - A fill to an already-present slot overwrites the data; no error is raised.
- Squash: on squash_val, present[squash_slot] <= 0.
  - Squash and fill to the same slot in the same cycle: squash wins, present=0.
- Commit (with commit_wen=1):
  - Source data: if fill_val and fill_slot==commit_slot in the same cycle, use fill_data (forwarded); otherwise use data[commit_slot], provided present[commit_slot]=1.
  - Success: next cycle rf_wen=1, rf_waddr=commit_rf_waddr, rf_wdata=source data. present[commit_slot] <= 0 (this overrides any same-cycle fill or squash to that slot). commit_count increments.
  - commit_rf_waddr==0: the entry retires and commit_count increments, but rf_wen=0 (r0 is never written).
  - Failure (slot not present and no same-cycle fill): rf_wen=0, present is unchanged, commit_count does not increment, commit_err <= 1 and stays set until reset.
- rf_wen is 0 in every cycle that does not follow a successful commit. rf_waddr and rf_wdata hold their last values when rf_wen=0.
- Commit latency: exactly 1 cycle from commit_wen to rf_wen. Back-to-back commits give back-to-back writes, with no bubbles.
- Bypass: purely combinational from the present/data arrays. byp_hit = present[byp_slot].
  - A same-cycle fill is not visible to bypass until the next cycle.
  - A slot being committed still reads as a hit during the commit cycle.
- Slot indices are used modulo 2^SLOT_W. There is no ordering logic here; ordering is owned by the ROB.
- commit_count wraps from 2^COUNT_W-1 to 0 without any flag.
- Reset asserted mid-operation: outputs go to their reset values immediately. A commit in flight is dropped (no rf_wen after reset is released).

Test Plan:
- Fill slot 3 with 0xDEADBEEF; next cycle commit slot 3 with waddr 7 -> the following cycle shows rf_wen=1, rf_waddr=7, rf_wdata=0xDEADBEEF; commit_count=1; byp_slot=3 then gives byp_hit=0.
- Fill slot 5 with 0x1234 and commit slot 5 (waddr 2) in the same cycle -> next cycle rf_wen=1, rf_wdata=0x1234; present[5]=0.
- Commit slot 9 with no prior fill -> rf_wen=0, commit_err=1 and stays 1; commit_count unchanged. Then fill slot 9 and commit it -> the write succeeds and commit_err remains 1.
- Fill slots 0..15 with value 0x100+i, then commit 0..15 on consecutive cycles with waddr=i -> 15 consecutive writes for r1..r15 carrying the right data; no write for r0; commit_count=16.
- Fill slot 4, then squash slot 4 and fill slot 4 in the same cycle -> byp_hit=0 for slot 4; a later commit of slot 4 sets commit_err.
- Fill slot 1, commit slot 1, and assert reset during the cycle after the commit -> rf_wen=0, commit_count=0, byp_hit=0 for slot 1 after reset.
